echo_delay_ctrl: RTL and testbench
==================================

// Module: echo_delay_ctrl
// PURPOSE
//  Initiator side of the 4-bank SPRAM sample memory. Uses it as a circular
//  audio delay line: one write and one delayed read per input sample.
//  Produces an echo-mixed output and writes feedback back into the line.
//  Sits between the I2S/codec sample path and the SPRAM memory wrapper.
// PARAMETERS
//  BITSIZE    24  sample width, signed two's complement; equals memory word width
//  ADDRLEN    16  memory address width; delay line depth = 2**ADDRLEN words
//  MIX_SHIFT  1   output mix: y = x + (d >>> MIX_SHIFT)
// PORTS
//  clk               in   1        system clock
//  reset             in   1        synchronous, active-high reset
//  sample_in         in   BITSIZE  input sample x
//  sample_valid      in   1        1-cycle strobe; sample_in valid
//  delay             in   ADDRLEN  delay in samples; 0 = full depth
//  fb_shift          in   3        feedback: 0 = off, else d >>> fb_shift
//  sample_out        out  BITSIZE  mixed output sample y
//  sample_out_valid  out  1        1-cycle strobe; sample_out valid
//  busy              out  1        high while clearing or processing a sample
//  overrun           out  1        sticky: sample_valid arrived while busy
//  mem_addr          out  ADDRLEN  memory address
//  mem_datain        out  BITSIZE  memory write data
//  mem_wren          out  1        memory write enable
//  mem_dataout       in   BITSIZE  memory read data; registered, 1-cycle latency
// BEHAVIOUR
//  - Reset: all outputs 0, wr_ptr=0, overrun=0. FSM enters CLEAR.
//  - CLEAR: writes 0 to addr 0..2**ADDRLEN-1, one word per cycle.
//    mem_wren=1, busy=1. Then goes to IDLE. sample_valid is ignored here and
//    does not set overrun.
//  - IDLE: busy=0, mem_wren=0. On sample_valid:
//    latch x=sample_in, latch delay and fb_shift, go to READ.
//  - READ (cycle 1): mem_addr = (wr_ptr - delay) mod 2**ADDRLEN, wren=0.
//    delay=0 addresses wr_ptr itself, giving the oldest sample.
//  - CAPTURE (cycle 2): mem_addr held at the read address. The bank select
//    for read data is decoded from the current address. Latch d=mem_dataout.
//  - WRITE (cycle 3): mem_addr=wr_ptr, mem_wren=1.
//    mem_datain = sat(x + (d>>>fb_shift)), or x when fb_shift=0.
//    sample_out <= sat(x + (d>>>MIX_SHIFT)).
//    wr_ptr increments and wraps 2**ADDRLEN-1 -> 0. Go to IDLE.
//  - sample_out_valid pulses in cycle 4, i.e. 4 cycles after sample_valid.
//    sample_out holds its value until the next update.
//  - busy=1 in READ/CAPTURE/WRITE. sample_valid accepted again from cycle 4.
//  - sample_valid while busy: the sample is dropped and overrun is set.
//    overrun clears only on reset.
//  - sat(): sum formed in BITSIZE+1 bits. Clamp to 2**(BITSIZE-1)-1 or
//    -2**(BITSIZE-1). Shifts are arithmetic.
//  - mem_wren is never high outside CLEAR/WRITE.
//  - Reset mid-operation: abort, restart CLEAR, no sample_out_valid pulse.
// TESTING (bench: ADDRLEN=4, behavioural 1-cycle-latency memory model)
//  1. Reset -> 16 consecutive writes of 0 to addr 0..15, busy low after,
//     outputs 0.
//  2. delay=3, fb_shift=0; impulse 1000 then zeros, spaced 8 cycles ->
//     sample_out 1000, 0, 0, 500, 0...; valid exactly 4 cycles after each strobe.
//  3. delay=2, fb_shift=1; impulse 4096 -> written 4096, 2048, 1024 at
//     intervals of 2; outputs 4096, 2048, 1024, 512.
//  4. x=0x7FFFF0 with stored d=0x7FFFF0, MIX_SHIFT=1 -> sample_out=0x7FFFFF;
//     negative case -> 0x800000.
//  5. delay=0, 17 samples -> read addr = write addr; output 17 echoes sample 1;
//     wr_ptr wraps 15->0.
//  6. sample_valid 2 cycles after the prior strobe -> dropped, overrun=1;
//     reset in CAPTURE -> no valid pulse, CLEAR restarts.

Source files
------------

// File: rtl/echo_delay_ctrl.sv
// rtl/echo_delay_ctrl.sv - circular SPRAM delay line with echo mix and feedback write-back
module echo_delay_ctrl #(
    parameter int BITSIZE   = 24,
    parameter int ADDRLEN   = 16,
    parameter int MIX_SHIFT = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [BITSIZE-1:0] sample_in,
    input  logic               sample_valid,
    input  logic [ADDRLEN-1:0] delay,
    input  logic [2:0]         fb_shift,
    output logic [BITSIZE-1:0] sample_out,
    output logic               sample_out_valid,
    output logic               busy,
    output logic               overrun,
    output logic [ADDRLEN-1:0] mem_addr,
    output logic [BITSIZE-1:0] mem_datain,
    output logic               mem_wren,
    input  logic [BITSIZE-1:0] mem_dataout
);

    typedef enum logic [2:0] {
        S_CLEAR   = 3'd0,
        S_IDLE    = 3'd1,
        S_READ    = 3'd2,
        S_CAPTURE = 3'd3,
        S_WRITE   = 3'd4
    } state_t;

    localparam logic [ADDRLEN-1:0] ADDR_ONE = 1;

    state_t             state_q, state_d;
    logic [ADDRLEN-1:0] clr_cnt_q, clr_cnt_d;
    logic               clr_last_q, clr_last_d;
    logic [ADDRLEN-1:0] wr_ptr_q, wr_ptr_d;
    logic [BITSIZE-1:0] x_q, x_d;
    logic [2:0]         fb_q, fb_d;
    logic [BITSIZE-1:0] d_q, d_d;
    logic [BITSIZE-1:0] sample_out_q, sample_out_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic               overrun_q, overrun_d;
    logic [ADDRLEN-1:0] mem_addr_q, mem_addr_d;
    logic [BITSIZE-1:0] mem_datain_q, mem_datain_d;
    logic               mem_wren_q, mem_wren_d;

    logic signed [BITSIZE-1:0] fb_term;
    logic signed [BITSIZE-1:0] mix_term;

    // Sum in BITSIZE+1 bits; overflow shows as the top two bits disagreeing.
    function automatic logic [BITSIZE-1:0] sat_add(input logic [BITSIZE-1:0] a,
                                                   input logic [BITSIZE-1:0] b);
        logic [BITSIZE:0] s;
        s = {a[BITSIZE-1], a} + {b[BITSIZE-1], b};
        if (s[BITSIZE] != s[BITSIZE-1])
            sat_add = s[BITSIZE] ? {1'b1, {(BITSIZE-1){1'b0}}} : {1'b0, {(BITSIZE-1){1'b1}}};
        else
            sat_add = s[BITSIZE-1:0];
    endfunction

    assign fb_term  = $signed(mem_dataout) >>> fb_q;
    assign mix_term = $signed(d_q) >>> MIX_SHIFT;

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        clr_last_d   = clr_last_q;
        wr_ptr_d     = wr_ptr_q;
        x_d          = x_q;
        fb_d         = fb_q;
        d_d          = d_q;
        sample_out_d = sample_out_q;
        out_valid_d  = 1'b0;
        busy_d       = busy_q;
        overrun_d    = overrun_q;
        mem_addr_d   = mem_addr_q;
        mem_datain_d = mem_datain_q;
        mem_wren_d   = mem_wren_q;

        case (state_q)
            S_CLEAR: begin
                if (!clr_last_q) begin
                    mem_addr_d   = clr_cnt_q;
                    mem_datain_d = '0;
                    mem_wren_d   = 1'b1;
                    busy_d       = 1'b1;
                    clr_cnt_d    = clr_cnt_q + ADDR_ONE;
                    clr_last_d   = (clr_cnt_q == {ADDRLEN{1'b1}});
                end else begin
                    mem_addr_d = '0;
                    mem_wren_d = 1'b0;
                    busy_d     = 1'b0;
                    clr_last_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            S_IDLE: begin
                if (sample_valid) begin
                    x_d        = sample_in;
                    fb_d       = fb_shift;
                    mem_addr_d = wr_ptr_q - delay;
                    busy_d     = 1'b1;
                    state_d    = S_READ;
                end
            end
            S_READ: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                // Read data is valid now; the write word is formed straight from it.
                d_d          = mem_dataout;
                mem_addr_d   = wr_ptr_q;
                mem_wren_d   = 1'b1;
                mem_datain_d = (fb_q == 3'd0) ? x_q : sat_add(x_q, fb_term);
                state_d      = S_WRITE;
            end
            S_WRITE: begin
                mem_wren_d   = 1'b0;
                busy_d       = 1'b0;
                sample_out_d = sat_add(x_q, mix_term);
                out_valid_d  = 1'b1;
                wr_ptr_d     = wr_ptr_q + ADDR_ONE;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_CLEAR;
            end
        endcase

        if (sample_valid && (state_q == S_READ || state_q == S_CAPTURE || state_q == S_WRITE))
            overrun_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_CLEAR;
            clr_cnt_q    <= '0;
            clr_last_q   <= 1'b0;
            wr_ptr_q     <= '0;
            x_q          <= '0;
            fb_q         <= '0;
            d_q          <= '0;
            sample_out_q <= '0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_datain_q <= '0;
            mem_wren_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            clr_last_q   <= clr_last_d;
            wr_ptr_q     <= wr_ptr_d;
            x_q          <= x_d;
            fb_q         <= fb_d;
            d_q          <= d_d;
            sample_out_q <= sample_out_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
            mem_addr_q   <= mem_addr_d;
            mem_datain_q <= mem_datain_d;
            mem_wren_q   <= mem_wren_d;
        end
    end

    assign sample_out       = sample_out_q;
    assign sample_out_valid = out_valid_q;
    assign busy             = busy_q;
    assign overrun          = overrun_q;
    assign mem_addr         = mem_addr_q;
    assign mem_datain       = mem_datain_q;
    assign mem_wren         = mem_wren_q;

endmodule

// File: tb/tb_echo_delay_ctrl.sv
// tb/tb_echo_delay_ctrl.sv - self-checking bench for echo_delay_ctrl with a 16-word line
module tb_echo_delay_ctrl;

    localparam int BW    = 24;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [BW-1:0] sample_in = '0;
    logic          sample_valid = 1'b0;
    logic [AW-1:0] dly = '0;
    logic [2:0]    fb = '0;
    logic [BW-1:0] sample_out;
    logic          sample_out_valid;
    logic          busy;
    logic          overrun;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_datain;
    logic          mem_wren;
    logic [BW-1:0] mem_dataout = '0;

    logic [BW-1:0] mem [DEPTH];

    int checks = 0;
    int failures = 0;

    int ref_line [DEPTH];
    int ref_wp;

    echo_delay_ctrl #(.BITSIZE(BW), .ADDRLEN(AW), .MIX_SHIFT(1)) dut (
        .clk              (clk),
        .reset            (reset),
        .sample_in        (sample_in),
        .sample_valid     (sample_valid),
        .delay            (dly),
        .fb_shift         (fb),
        .sample_out       (sample_out),
        .sample_out_valid (sample_out_valid),
        .busy             (busy),
        .overrun          (overrun),
        .mem_addr         (mem_addr),
        .mem_datain       (mem_datain),
        .mem_wren         (mem_wren),
        .mem_dataout      (mem_dataout)
    );

    always #5 clk = ~clk;

    // Synchronous memory: registered read, 1-cycle latency.
    always @(posedge clk) begin
        if (mem_wren) mem[mem_addr] <= mem_datain;
        mem_dataout <= mem[mem_addr];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int s24(input logic [BW-1:0] v);
        return int'($signed(v));
    endfunction

    function automatic int sat24(input int v);
        if (v > 8388607) return 8388607;
        if (v < -8388608) return -8388608;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) ref_line[i] = 0;
        ref_wp = 0;
    endtask

    task automatic model_step(input int x, input int delay, input int fbs,
                              output int raddr, output int wdata, output int y);
        int d;
        raddr = (((ref_wp - delay) % DEPTH) + DEPTH) % DEPTH;
        d = ref_line[raddr];
        y = sat24(x + (d >>> 1));
        wdata = (fbs == 0) ? x : sat24(x + (d >>> fbs));
        ref_line[ref_wp] = wdata;
        ref_wp = (ref_wp + 1) % DEPTH;
    endtask

    // Called at a negedge; holds reset two edges, checks reset values, then the clear sweep.
    task automatic do_reset(input bit inject_valid);
        reset = 1'b1;
        sample_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_out", sample_out, 0);
        chk("rst_valid", sample_out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_wren", mem_wren, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_datain", mem_datain, 0);
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            sample_valid = inject_valid && (i == 5);
            chk("clr_wren", mem_wren, 1);
            chk("clr_addr", mem_addr, i);
            chk("clr_data", mem_datain, 0);
            chk("clr_busy", busy, 1);
        end
        sample_valid = 1'b0;
        @(negedge clk);
        chk("clr_done_wren", mem_wren, 0);
        chk("clr_done_busy", busy, 0);
        chk("clr_overrun", overrun, 0);
        chk("clr_valid", sample_out_valid, 0);
        model_reset();
    endtask

    // Called at a negedge; returns at the negedge of the output strobe (cycle 4).
    task automatic send_sample(input logic [BW-1:0] x, input int delay, input int fbs,
                               input bit use_exp, input logic [BW-1:0] exp_out,
                               input logic [BW-1:0] exp_w);
        int ra, w, y, wp;
        logic [BW-1:0] eo, ew;
        wp = ref_wp;
        model_step(s24(x), delay, fbs, ra, w, y);
        eo = use_exp ? exp_out : y[BW-1:0];
        ew = use_exp ? exp_w : w[BW-1:0];
        sample_in = x;
        dly = delay[AW-1:0];
        fb = fbs[2:0];
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        chk("rd_addr", mem_addr, ra);
        chk("rd_wren", mem_wren, 0);
        chk("rd_busy", busy, 1);
        chk("rd_valid", sample_out_valid, 0);
        @(negedge clk);
        chk("cap_addr", mem_addr, ra);
        chk("cap_wren", mem_wren, 0);
        @(negedge clk);
        chk("wr_wren", mem_wren, 1);
        chk("wr_addr", mem_addr, wp);
        chk("wr_data", mem_datain, ew);
        chk("wr_valid", sample_out_valid, 0);
        @(negedge clk);
        chk("out_valid", sample_out_valid, 1);
        chk("out_data", sample_out, eo);
        chk("out_busy", busy, 0);
        chk("out_wren", mem_wren, 0);
    endtask

    typedef struct {
        bit            rst;
        logic [BW-1:0] x;
        int            delay;
        int            fbs;
        logic [BW-1:0] exp_out;
        logic [BW-1:0] exp_w;
        int            gap;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int x1, x17, ra, w, y, gap;
        logic [BW-1:0] xr;

        // impulse with plain echo, strobes 8 cycles apart
        tbl.push_back('{1'b1, 24'd1000, 3, 0, 24'd1000, 24'd1000, 4});
        tbl.push_back('{1'b0, 24'd0,    3, 0, 24'd0,    24'd0,    4});
        tbl.push_back('{1'b0, 24'd0,    3, 0, 24'd0,    24'd0,    4});
        tbl.push_back('{1'b0, 24'd0,    3, 0, 24'd500,  24'd0,    4});
        tbl.push_back('{1'b0, 24'd0,    3, 0, 24'd0,    24'd0,    4});
        // impulse with feedback, back-to-back strobes
        tbl.push_back('{1'b1, 24'd4096, 2, 1, 24'd4096, 24'd4096, 0});
        tbl.push_back('{1'b0, 24'd0,    2, 1, 24'd0,    24'd0,    0});
        tbl.push_back('{1'b0, 24'd0,    2, 1, 24'd2048, 24'd2048, 0});
        tbl.push_back('{1'b0, 24'd0,    2, 1, 24'd0,    24'd0,    0});
        tbl.push_back('{1'b0, 24'd0,    2, 1, 24'd1024, 24'd1024, 0});
        tbl.push_back('{1'b0, 24'd0,    2, 1, 24'd0,    24'd0,    0});
        tbl.push_back('{1'b0, 24'd0,    2, 1, 24'd512,  24'd512,  0});
        // saturation, positive then negative
        tbl.push_back('{1'b1, 24'h7FFFF0, 1, 0, 24'h7FFFF0, 24'h7FFFF0, 1});
        tbl.push_back('{1'b0, 24'h7FFFF0, 1, 0, 24'h7FFFFF, 24'h7FFFF0, 1});
        tbl.push_back('{1'b0, 24'h7FFFF0, 1, 1, 24'h7FFFFF, 24'h7FFFFF, 1});
        tbl.push_back('{1'b1, 24'h800010, 1, 0, 24'h800010, 24'h800010, 1});
        tbl.push_back('{1'b0, 24'h800010, 1, 0, 24'h800000, 24'h800010, 1});
        tbl.push_back('{1'b0, 24'h800010, 1, 1, 24'h800000, 24'h800000, 1});

        @(negedge clk);
        do_reset(1'b1);

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset(1'b0);
            send_sample(tbl[i].x, tbl[i].delay, tbl[i].fbs, 1'b1, tbl[i].exp_out, tbl[i].exp_w);
            for (int g = 0; g < tbl[i].gap; g++) @(negedge clk);
        end

        // delay 0 reads the oldest word; the 17th sample echoes the 1st after wrap
        do_reset(1'b0);
        x1 = 0;
        x17 = 0;
        for (int k = 0; k < 17; k++) begin
            xr = BW'($urandom_range(0, 24'h3FFFFF));
            if (k == 0) x1 = s24(xr);
            if (k == 16) x17 = s24(xr);
            send_sample(xr, 0, 0, 1'b0, '0, '0);
        end
        chk("wrap_echo", sample_out, 32'(sat24(x17 + (x1 >>> 1))) & 32'hFFFFFF);

        // sample during busy is dropped and sets sticky overrun
        do_reset(1'b0);
        model_step(100, 1, 0, ra, w, y);
        sample_in = 24'd100;
        dly = 4'd1;
        fb = 3'd0;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        chk("ovr_before", overrun, 0);
        @(negedge clk);
        sample_in = 24'd12345;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        chk("ovr_set", overrun, 1);
        chk("ovr_wr_data", mem_datain, w);
        @(negedge clk);
        chk("ovr_out_valid", sample_out_valid, 1);
        chk("ovr_out", sample_out, y);
        @(negedge clk);
        chk("ovr_no_extra", sample_out_valid, 0);
        send_sample(24'd0, 1, 0, 1'b0, '0, '0);
        chk("ovr_sticky", overrun, 1);

        // reset while in CAPTURE aborts without an output strobe
        sample_in = 24'd777;
        dly = 4'd2;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 1);
        do_reset(1'b0);

        // randomized traffic against the model
        for (int k = 0; k < 40; k++) begin
            xr = BW'($urandom);
            send_sample(xr, int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 7)),
                        1'b0, '0, '0);
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) @(negedge clk);
        end
        chk("rand_overrun", overrun, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
